// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: requester request/response bus plus the shared ALU port bundle.
interface alu_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*32-1:0] req_in_1;
  logic [NUM_REQ*32-1:0] req_in_2;
  logic [NUM_REQ*4-1:0]  req_op;
  logic [NUM_REQ-1:0]    resp_valid;
  logic [NUM_REQ-1:0]    resp_ready;
  logic [31:0]           resp_data;
  logic [IDX_W-1:0]      resp_id;
  logic                  busy;
  logic [31:0]           alu_in_1;
  logic [31:0]           alu_in_2;
  logic [3:0]            alu_operation;
  logic [31:0]           alu_out;
  modport slave (
    input  req_valid, req_in_1, req_in_2, req_op, resp_ready, alu_out,
    output req_ready, resp_valid, resp_data, resp_id, busy, alu_in_1, alu_in_2, alu_operation
  );
  modport master (
    output req_valid, req_in_1, req_in_2, req_op, resp_ready, alu_out,
    input  req_ready, resp_valid, resp_data, resp_id, busy, alu_in_1, alu_in_2, alu_operation
  );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between NUM_REQ requesters.
module alu_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 2
) (
  input logic          clk,
  input logic          rst_n,
  alu_arbiter_if.slave bus
);
  localparam logic [3:0] NOP = 4'd14;
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t           state_q, state_d;
  logic [IDX_W-1:0] last_q, last_d, id_q, id_d, resp_id_q, resp_id_d, grant;
  logic [31:0]      in1_q, in1_d, in2_q, in2_d, resp_data_q, resp_data_d;
  logic [3:0]       op_q, op_d;
  logic             found;
  int               idx;
  // Scan from the requester after the last winner, wrapping, so nobody starves.
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = (int'(last_q) + k) % NUM_REQ;
      if (!found && ((bus.req_valid >> idx) & NUM_REQ'(1)) != '0) begin
        found = 1'b1;
        grant = IDX_W'(idx);
      end
    end
  end
  assign bus.req_ready     = (state_q == IDLE && found) ? NUM_REQ'(1) << grant : '0;
  assign bus.resp_valid    = (state_q == RESP) ? NUM_REQ'(1) << resp_id_q : '0;
  assign bus.resp_data     = resp_data_q;
  assign bus.resp_id       = resp_id_q;
  assign bus.busy          = state_q != IDLE;
  assign bus.alu_in_1      = (state_q == EXEC) ? in1_q : '0;
  assign bus.alu_in_2      = (state_q == EXEC) ? in2_q : '0;
  assign bus.alu_operation = (state_q == EXEC) ? op_q : NOP;
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    id_d        = id_q;
    in1_d       = in1_q;
    in2_d       = in2_q;
    op_d        = op_q;
    resp_data_d = resp_data_q;
    resp_id_d   = resp_id_q;
    if (state_q == IDLE && found) begin
      state_d = EXEC;
      last_d  = grant;
      id_d    = grant;
      in1_d   = 32'(bus.req_in_1 >> (32 * int'(grant)));
      in2_d   = 32'(bus.req_in_2 >> (32 * int'(grant)));
      op_d    = 4'(bus.req_op >> (4 * int'(grant)));
    end else if (state_q == EXEC) begin
      state_d     = RESP;
      resp_data_d = bus.alu_out;
      resp_id_d   = id_q;
    end else if (state_q == RESP && (bus.resp_ready & bus.resp_valid) != '0) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= IDX_W'(NUM_REQ - 1);
      id_q        <= '0;
      in1_q       <= '0;
      in2_q       <= '0;
      op_q        <= NOP;
      resp_data_q <= '0;
      resp_id_q   <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      id_q        <= id_d;
      in1_q       <= in1_d;
      in2_q       <= in2_d;
      op_q        <= op_d;
      resp_data_q <= resp_data_d;
      resp_id_q   <= resp_id_d;
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed checks of arbitration, ALU sequencing and response handshake.
module tb_alu_arbiter;
  localparam int N = 3;
  localparam int W = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  alu_arbiter_if #(.NUM_REQ(N), .IDX_W(W)) ifc ();
  alu_arbiter #(.NUM_REQ(N), .IDX_W(W)) dut (.clk(clk), .rst_n(rst_n), .bus(ifc));
  logic [31:0] a [N];
  logic [31:0] b [N];
  logic [3:0]  o [N];
  int checks = 0;
  int fails = 0;
  always_comb begin
    for (int i = 0; i < N; i++) begin
      ifc.req_in_1[32*i +: 32] = a[i];
      ifc.req_in_2[32*i +: 32] = b[i];
      ifc.req_op[4*i +: 4]     = o[i];
    end
  end
  // Stand-in ALU: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT (signed).
  always_comb begin
    case (ifc.alu_operation)
      4'd0:    ifc.alu_out = ifc.alu_in_1 + ifc.alu_in_2;
      4'd1:    ifc.alu_out = ifc.alu_in_1 - ifc.alu_in_2;
      4'd2:    ifc.alu_out = ifc.alu_in_1 & ifc.alu_in_2;
      4'd3:    ifc.alu_out = ifc.alu_in_1 | ifc.alu_in_2;
      4'd4:    ifc.alu_out = ifc.alu_in_1 ^ ifc.alu_in_2;
      4'd5:    ifc.alu_out = {31'd0, $signed(ifc.alu_in_1) < $signed(ifc.alu_in_2)};
      default: ifc.alu_out = 32'd0;
    endcase
  end
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    ifc.req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_reset();
    ifc.req_valid = '0;
    ifc.resp_ready = '0;
    for (int i = 0; i < N; i++) begin a[i] = '0; b[i] = '0; o[i] = '0; end
    #12;
    checks++; if (ifc.busy !== 1'b0) begin fails++; $display("FAIL rst busy got=%b exp=0", ifc.busy); end
    checks++; if (ifc.resp_valid !== 3'b000) begin fails++; $display("FAIL rst resp_valid got=%b exp=000", ifc.resp_valid); end
    checks++; if (ifc.resp_data !== 32'd0 || ifc.resp_id !== 2'd0) begin fails++; $display("FAIL rst resp got=%h/%0d exp=0/0", ifc.resp_data, ifc.resp_id); end
    checks++; if (ifc.alu_operation !== 4'd14 || ifc.alu_in_1 !== 32'd0 || ifc.alu_in_2 !== 32'd0) begin fails++; $display("FAIL rst alu got=%0d %h %h exp=14 0 0", ifc.alu_operation, ifc.alu_in_1, ifc.alu_in_2); end
    checks++; if (ifc.req_ready !== 3'b000) begin fails++; $display("FAIL rst req_ready got=%b exp=000", ifc.req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_single();
    @(negedge clk);
    a[0] = 32'd5; b[0] = 32'd7; o[0] = 4'd0; ifc.resp_ready = 3'b111; ifc.req_valid = 3'b001;
    #1;
    checks++; if (ifc.req_ready !== 3'b001) begin fails++; $display("FAIL t1 req_ready got=%b exp=001", ifc.req_ready); end
    @(negedge clk);
    ifc.req_valid = '0;
    #1;
    checks++; if (ifc.alu_operation !== 4'd0 || ifc.alu_in_1 !== 32'd5 || ifc.alu_in_2 !== 32'd7) begin fails++; $display("FAIL t1 alu got=%0d %0d %0d exp=0 5 7", ifc.alu_operation, ifc.alu_in_1, ifc.alu_in_2); end
    checks++; if (ifc.busy !== 1'b1) begin fails++; $display("FAIL t1 busy got=%b exp=1", ifc.busy); end
    @(negedge clk); #1;
    checks++; if (ifc.resp_valid !== 3'b001 || ifc.resp_data !== 32'd12 || ifc.resp_id !== 2'd0) begin fails++; $display("FAIL t1 resp got=%b %0d %0d exp=001 12 0", ifc.resp_valid, ifc.resp_data, ifc.resp_id); end
    checks++; if (ifc.alu_operation !== 4'd14) begin fails++; $display("FAIL t1 alu_nop got=%0d exp=14", ifc.alu_operation); end
    @(negedge clk); #1;
    checks++; if (ifc.busy !== 1'b0 || ifc.resp_valid !== 3'b000 || ifc.resp_data !== 32'd12) begin fails++; $display("FAIL t1 done got=%b %b %0d exp=0 000 12", ifc.busy, ifc.resp_valid, ifc.resp_data); end
  endtask
  task automatic test_simultaneous();
    do_reset();
    a[0] = 32'd10; b[0] = 32'd3; o[0] = 4'd1;
    a[1] = 32'hF0; b[1] = 32'hFF; o[1] = 4'd4;
    ifc.resp_ready = 3'b111; ifc.req_valid = 3'b011;
    #1;
    checks++; if (ifc.req_ready !== 3'b001) begin fails++; $display("FAIL t2 first_grant got=%b exp=001", ifc.req_ready); end
    @(negedge clk);
    ifc.req_valid = 3'b010;
    #1;
    checks++; if (ifc.req_ready !== 3'b000) begin fails++; $display("FAIL t2 busy_no_grant got=%b exp=000", ifc.req_ready); end
    @(negedge clk); #1;
    checks++; if (ifc.resp_valid !== 3'b001 || ifc.resp_data !== 32'd7) begin fails++; $display("FAIL t2 resp0 got=%b %0d exp=001 7", ifc.resp_valid, ifc.resp_data); end
    checks++; if (ifc.req_ready !== 3'b000) begin fails++; $display("FAIL t2 resp_no_grant got=%b exp=000", ifc.req_ready); end
    @(negedge clk); #1;
    checks++; if (ifc.req_ready !== 3'b010) begin fails++; $display("FAIL t2 second_grant got=%b exp=010", ifc.req_ready); end
    @(negedge clk);
    ifc.req_valid = '0;
    #1;
    checks++; if (ifc.alu_operation !== 4'd4 || ifc.alu_in_1 !== 32'hF0) begin fails++; $display("FAIL t2 alu1 got=%0d %h exp=4 f0", ifc.alu_operation, ifc.alu_in_1); end
    @(negedge clk); #1;
    checks++; if (ifc.resp_valid !== 3'b010 || ifc.resp_data !== 32'h0F || ifc.resp_id !== 2'd1) begin fails++; $display("FAIL t2 resp1 got=%b %h %0d exp=010 0f 1", ifc.resp_valid, ifc.resp_data, ifc.resp_id); end
    @(negedge clk);
  endtask
  task automatic test_round_robin();
    logic [1:0] exp_id [6];
    exp_id[0] = 2'd0; exp_id[1] = 2'd1; exp_id[2] = 2'd2;
    exp_id[3] = 2'd0; exp_id[4] = 2'd1; exp_id[5] = 2'd2;
    do_reset();
    for (int i = 0; i < N; i++) begin a[i] = i; b[i] = 32'd100; o[i] = 4'd0; end
    ifc.resp_ready = 3'b111; ifc.req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      bit got;
      got = 1'b0;
      for (int c = 0; c < 10 && !got; c++) begin
        @(negedge clk); #1;
        if (ifc.resp_valid !== 3'b000) got = 1'b1;
      end
      checks++;
      if (!got) begin fails++; $display("FAIL t3 timeout txn=%0d got=no_resp exp=resp", k); end
      else if (ifc.resp_id !== exp_id[k] || ifc.resp_data !== 32'd100 + 32'(exp_id[k]) || ifc.resp_valid !== 3'(3'b001 << exp_id[k])) begin
        fails++; $display("FAIL t3 txn=%0d got=%0d/%0d/%b exp=%0d/%0d", k, ifc.resp_id, ifc.resp_data, ifc.resp_valid, exp_id[k], 100 + exp_id[k]);
      end
    end
    ifc.req_valid = '0;
    @(negedge clk); @(negedge clk);
  endtask
  task automatic test_backpressure();
    do_reset();
    a[1] = 32'hFFFF_FFFF; b[1] = 32'd1; o[1] = 4'd5;
    a[0] = 32'hFF00; b[0] = 32'h0F0F; o[0] = 4'd2;
    ifc.resp_ready = 3'b101; ifc.req_valid = 3'b010;
    #1;
    checks++; if (ifc.req_ready !== 3'b010) begin fails++; $display("FAIL t4 grant1 got=%b exp=010", ifc.req_ready); end
    @(negedge clk);
    ifc.req_valid = 3'b001;
    #1;
    checks++; if (ifc.req_ready !== 3'b000) begin fails++; $display("FAIL t4 exec_no_grant got=%b exp=000", ifc.req_ready); end
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      checks++;
      if (ifc.resp_valid !== 3'b010 || ifc.resp_data !== 32'd1 || ifc.req_ready !== 3'b000) begin
        fails++; $display("FAIL t4 hold cyc=%0d got=%b %0d %b exp=010 1 000", c, ifc.resp_valid, ifc.resp_data, ifc.req_ready);
      end
    end
    ifc.resp_ready = 3'b010;
    @(negedge clk); #1;
    checks++; if (ifc.req_ready !== 3'b001 || ifc.resp_valid !== 3'b000 || ifc.resp_data !== 32'd1) begin fails++; $display("FAIL t4 release got=%b %b %0d exp=001 000 1", ifc.req_ready, ifc.resp_valid, ifc.resp_data); end
    ifc.resp_ready = 3'b111;
    @(negedge clk);
    ifc.req_valid = '0;
    #1;
    checks++; if (ifc.alu_operation !== 4'd2 || ifc.alu_in_1 !== 32'hFF00 || ifc.alu_in_2 !== 32'h0F0F) begin fails++; $display("FAIL t4 alu0 got=%0d %h %h exp=2 ff00 0f0f", ifc.alu_operation, ifc.alu_in_1, ifc.alu_in_2); end
    @(negedge clk); #1;
    checks++; if (ifc.resp_valid !== 3'b001 || ifc.resp_data !== 32'h0F00) begin fails++; $display("FAIL t4 resp0 got=%b %h exp=001 0f00", ifc.resp_valid, ifc.resp_data); end
    @(negedge clk);
  endtask
  task automatic test_reset_mid_exec();
    do_reset();
    a[0] = 32'hF0F0; b[0] = 32'hFF; o[0] = 4'd2;
    ifc.resp_ready = 3'b111; ifc.req_valid = 3'b001;
    @(negedge clk);
    ifc.req_valid = '0;
    #1;
    checks++; if (ifc.busy !== 1'b1 || ifc.alu_operation !== 4'd2) begin fails++; $display("FAIL t5 in_exec got=%b %0d exp=1 2", ifc.busy, ifc.alu_operation); end
    rst_n = 1'b0;
    #1;
    checks++; if (ifc.busy !== 1'b0 || ifc.resp_valid !== 3'b000 || ifc.alu_operation !== 4'd14 || ifc.alu_in_1 !== 32'd0 || ifc.resp_data !== 32'd0) begin
      fails++; $display("FAIL t5 async got=%b %b %0d %h %h exp=0 000 14 0 0", ifc.busy, ifc.resp_valid, ifc.alu_operation, ifc.alu_in_1, ifc.resp_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); #1;
      checks++;
      if (ifc.resp_valid !== 3'b000 || ifc.busy !== 1'b0) begin fails++; $display("FAIL t5 after cyc=%0d got=%b %b exp=000 0", c, ifc.resp_valid, ifc.busy); end
    end
  endtask
  task automatic test_idle();
    ifc.req_valid = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      checks++;
      if (ifc.req_ready !== 3'b000 || ifc.alu_operation !== 4'd14 || ifc.alu_in_1 !== 32'd0 || ifc.alu_in_2 !== 32'd0 || ifc.busy !== 1'b0) begin
        fails++; $display("FAIL t6 idle cyc=%0d got=%b %0d %h %h %b exp=000 14 0 0 0", c, ifc.req_ready, ifc.alu_operation, ifc.alu_in_1, ifc.alu_in_2, ifc.busy);
      end
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_simultaneous();
    test_round_robin();
    test_backpressure();
    test_reset_mid_exec();
    test_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
